// File: rtl/jacobi_pkg.sv
// Shared definitions for the Jacobi iteration controller: global bus geometry,
// state encoding (identical to the STATUS state field) and register offsets.
package jacobi_pkg;

    localparam int GlobalAddrWidth = 8;
    localparam int GlobalDataWidth = 16;

    // The global read bus is OR-combined, so a slave that is not addressed
    // contributes all zeros.
    localparam logic [GlobalDataWidth-1:0] GlobalDataHighZ = '0;

    typedef enum logic [1:0] {
        JS_IDLE = 2'd0,
        JS_STEP = 2'd1,
        JS_EVAL = 2'd2,
        JS_DONE = 2'd3
    } jstate_e;

    localparam logic [1:0] JR_ITER   = 2'd0;
    localparam logic [1:0] JR_THRESH = 2'd1;
    localparam logic [1:0] JR_STATUS = 2'd2;
    localparam logic [1:0] JR_CMD    = 2'd3;

endpackage

// File: rtl/jacobi_max_reduce.sv
// Combinational maximum over NCH unsigned channels, built as a balanced
// binary tree so depth grows with log2(NCH). Missing leaves are zero.
module jacobi_max_reduce #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic [NCH*WIDTH-1:0] delta,
    output logic [WIDTH-1:0]     maxd
);

    localparam int LEAVES = 1 << $clog2(NCH);

    logic [LEAVES*WIDTH-1:0] padded;
    logic [WIDTH-1:0]        node [1:2*LEAVES-1];

    // Heap-ordered tree: node i compares its children 2i and 2i+1.
    always_comb begin
        padded = '0;
        padded[NCH*WIDTH-1:0] = delta;
        for (int i = 0; i < LEAVES; i++) begin
            node[LEAVES+i] = padded[i*WIDTH +: WIDTH];
        end
        for (int i = LEAVES - 1; i >= 1; i--) begin
            node[i] = (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
        end
        maxd = node[1];
    end

endmodule

// File: rtl/jacobi_iter_ctrl.sv
// Iteration controller for the Jacobi array: pulses Enable once per
// iteration, reduces the channel deltas and stops on budget or convergence.
//
// state | meaning
// IDLE  | parked after reset or abort, Enable low
// STEP  | Enable high for one cycle, array updates on the next edge
// EVAL  | Delta valid; reduce, count hits, decide next step
// DONE  | run finished, Done high until next ITER write or abort
module jacobi_iter_ctrl
    import jacobi_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CWIDTH  = 8,
    parameter int IDWIDTH = 8,
    parameter int NCH     = 4,
    parameter int HITS    = 2
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       RD,
    input  logic                       WR,
    input  logic [GlobalAddrWidth-1:0] Addr,
    input  logic [GlobalDataWidth-1:0] DataIn,
    output logic [GlobalDataWidth-1:0] DataOut,
    input  logic [IDWIDTH-1:0]         Id,
    input  logic [NCH*WIDTH-1:0]       Delta,
    output logic                       Enable,
    output logic                       Done,
    output logic                       Converged
);

    localparam int              HITS_W   = $clog2(HITS + 1);
    localparam logic [HITS_W-1:0] HITS_MAX = HITS_W'(HITS);

    jstate_e             state_q, state_d;
    logic [CWIDTH-1:0]   remaining_q, remaining_d;
    logic [CWIDTH-1:0]   iters_q, iters_d;
    logic [HITS_W-1:0]   hits_q, hits_d;
    logic [WIDTH-1:0]    thresh_q, thresh_d;
    logic                done_q, done_d;
    logic                conv_q, conv_d;
    logic                enable_q, enable_d;

    logic [WIDTH-1:0]    maxd;
    logic [IDWIDTH-1:0]  offset;
    logic                addr_hit;
    logic [1:0]          reg_sel;
    logic                wr_iter, wr_thresh, wr_cmd;
    logic [GlobalDataWidth-1:0] rdata;
    logic                unused_bits;

    jacobi_max_reduce #(.WIDTH(WIDTH), .NCH(NCH)) u_max (
        .delta (Delta),
        .maxd  (maxd)
    );

    // Subtracting the base makes Id+k wrap modulo 2^IDWIDTH for free.
    assign offset    = Addr[IDWIDTH-1:0] - Id;
    assign addr_hit  = ({1'b0, offset} < (IDWIDTH+1)'(4));
    assign reg_sel   = offset[1:0];
    assign wr_iter   = WR && addr_hit && (reg_sel == JR_ITER);
    assign wr_thresh = WR && addr_hit && (reg_sel == JR_THRESH);
    assign wr_cmd    = WR && addr_hit && (reg_sel == JR_CMD);

    assign unused_bits = ^{DataIn, Addr};

    // Next-state logic: bus commands override the sequencer in the same cycle.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        iters_d     = iters_q;
        hits_d      = hits_q;
        thresh_d    = thresh_q;
        done_d      = done_q;
        conv_d      = conv_q;

        if (wr_iter) begin
            hits_d      = '0;
            iters_d     = '0;
            conv_d      = 1'b0;
            remaining_d = DataIn[CWIDTH-1:0];
            if (DataIn[CWIDTH-1:0] != '0) begin
                state_d = JS_STEP;
                done_d  = 1'b0;
            end else begin
                state_d = JS_DONE;
                done_d  = 1'b1;
            end
        end else if (wr_cmd && DataIn[0]) begin
            // Abort leaves the counters untouched so they can be inspected.
            state_d = JS_IDLE;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                JS_STEP: state_d = JS_EVAL;
                JS_EVAL: begin
                    if (maxd <= thresh_q) begin
                        hits_d = (hits_q == HITS_MAX) ? hits_q : hits_q + 1'b1;
                    end else begin
                        hits_d = '0;
                    end
                    remaining_d = remaining_q - 1'b1;
                    if (iters_q != '1) begin
                        iters_d = iters_q + 1'b1;
                    end
                    // Convergence wins over an exhausted budget.
                    if (hits_d == HITS_MAX) begin
                        state_d = JS_DONE;
                        done_d  = 1'b1;
                        conv_d  = 1'b1;
                    end else if (remaining_d == '0) begin
                        state_d = JS_DONE;
                        done_d  = 1'b1;
                        conv_d  = 1'b0;
                    end else begin
                        state_d = JS_STEP;
                    end
                end
                default: ;
            endcase
        end

        if (wr_thresh) begin
            thresh_d = DataIn[WIDTH-1:0];
        end

        enable_d = (state_d == JS_STEP);
    end

    // State and registered outputs; reset clears Enable without a clock.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= JS_IDLE;
            remaining_q <= '0;
            iters_q     <= '0;
            hits_q      <= '0;
            thresh_q    <= '0;
            done_q      <= 1'b0;
            conv_q      <= 1'b0;
            enable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            iters_q     <= iters_d;
            hits_q      <= hits_d;
            thresh_q    <= thresh_d;
            done_q      <= done_d;
            conv_q      <= conv_d;
            enable_q    <= enable_d;
        end
    end

    // Combinational register read mux, zero-filled above each field.
    always_comb begin
        rdata = '0;
        case (reg_sel)
            JR_ITER:   rdata[CWIDTH-1:0] = remaining_q;
            JR_THRESH: rdata[WIDTH-1:0]  = thresh_q;
            JR_STATUS: begin
                rdata[1:0]          = state_q;
                rdata[2]            = done_q;
                rdata[3]            = conv_q;
                rdata[CWIDTH+3:4]   = iters_q;
            end
            default: ;
        endcase
    end

    assign DataOut   = (RD && addr_hit) ? rdata : GlobalDataHighZ;
    assign Enable    = enable_q;
    assign Done      = done_q;
    assign Converged = conv_q;

endmodule

// File: tb/tb_jacobi_iter_ctrl.sv
// Bench for jacobi_iter_ctrl: a run-level reference model checked against the
// DUT every cycle, directed scenarios with literal expectations, then
// randomized bus traffic and deltas.
module tb_jacobi_iter_ctrl;
    import jacobi_pkg::*;

    localparam int WIDTH = 8, CWIDTH = 8, IDWIDTH = 8, NCH = 4, HITS = 2;

    logic Clk = 1'b0, Reset = 1'b0, RD = 1'b0, WR = 1'b0;
    logic [GlobalAddrWidth-1:0] Addr = '0;
    logic [GlobalDataWidth-1:0] DataIn = '0;
    logic [GlobalDataWidth-1:0] DataOut;
    logic [IDWIDTH-1:0]         Id = 8'h10;
    logic [NCH*WIDTH-1:0]       Delta = '0;
    logic Enable, Done, Converged;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Model: mode 0 idle, 1 running, 2 done; cyc counts cycles since start.
    int m_mode = 0, m_cyc = 0, m_rem = 0, m_iters = 0, m_hits = 0, m_thr = 0;
    bit m_done = 1'b0, m_conv = 1'b0;

    jacobi_iter_ctrl #(.WIDTH(WIDTH), .CWIDTH(CWIDTH), .IDWIDTH(IDWIDTH),
                       .NCH(NCH), .HITS(HITS)) dut (
        .Clk(Clk), .Reset(Reset), .RD(RD), .WR(WR), .Addr(Addr),
        .DataIn(DataIn), .DataOut(DataOut), .Id(Id), .Delta(Delta),
        .Enable(Enable), .Done(Done), .Converged(Converged)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] ra(input int k);
        return Id + 8'(k);
    endfunction

    function automatic int max_delta(input logic [NCH*WIDTH-1:0] d);
        int m = 0;
        for (int c = 0; c < NCH; c++)
            if (int'(d[c*WIDTH +: WIDTH]) > m) m = int'(d[c*WIDTH +: WIDTH]);
        return m;
    endfunction

    function automatic int m_state();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 3;
        return (m_cyc % 2 == 0) ? 1 : 2;
    endfunction

    function automatic logic [15:0] exp_read();
        logic [15:0] r = GlobalDataHighZ;
        if (RD) begin
            if (Addr == ra(0))      r = 16'(m_rem);
            else if (Addr == ra(1)) r = 16'(m_thr);
            else if (Addr == ra(2)) r = 16'(m_state()) | (m_done ? 16'h4 : 16'h0)
                                      | (m_conv ? 16'h8 : 16'h0) | 16'(m_iters * 16);
            else if (Addr == ra(3)) r = 16'h0;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, advanced on each clock edge from the inputs seen there.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_mode = 0; m_cyc = 0; m_rem = 0; m_iters = 0; m_hits = 0; m_thr = 0;
            m_done = 1'b0; m_conv = 1'b0;
        end else begin
            int md;
            if (WR && Addr == ra(0)) begin
                m_rem = int'(DataIn[7:0]); m_iters = 0; m_hits = 0; m_conv = 1'b0;
                if (m_rem != 0) begin m_mode = 1; m_cyc = 0; m_done = 1'b0; end
                else begin m_mode = 2; m_done = 1'b1; end
            end else if (WR && Addr == ra(3) && DataIn[0]) begin
                m_mode = 0; m_done = 1'b0;
            end else if (m_mode == 1) begin
                if (m_cyc % 2 == 1) begin
                    md = max_delta(Delta);
                    if (md <= m_thr) m_hits = (m_hits < HITS) ? m_hits + 1 : HITS;
                    else m_hits = 0;
                    m_rem = m_rem - 1;
                    if (m_iters < 255) m_iters = m_iters + 1;
                    if (m_hits == HITS) begin m_mode = 2; m_done = 1'b1; m_conv = 1'b1; end
                    else if (m_rem == 0) begin m_mode = 2; m_done = 1'b1; m_conv = 1'b0; end
                end
                m_cyc = m_cyc + 1;
            end
            if (WR && Addr == ra(1)) m_thr = int'(DataIn[7:0]);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        chk("enable", 32'(Enable), 32'(m_mode == 1 && m_cyc % 2 == 0));
        chk("done", 32'(Done), 32'(m_done));
        chk("converged", 32'(Converged), 32'(m_conv));
        chk("dataout", 32'(DataOut), 32'(exp_read()));
        if (Enable) pulses++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [15:0] v);
        WR = 1'b1; Addr = a; DataIn = v;
        tick();
        WR = 1'b0;
    endtask

    task automatic rd_chk(input string name, input int k, input logic [15:0] exp);
        RD = 1'b1; Addr = ra(k);
        #1;
        chk(name, 32'(DataOut), 32'(exp));
        RD = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int c = 0; c < NCH; c++) Delta[c*WIDTH +: WIDTH] = 8'(v);
    endtask

    task automatic set_max(input int v);
        int ch = $urandom_range(0, NCH - 1);
        for (int c = 0; c < NCH; c++)
            Delta[c*WIDTH +: WIDTH] = (c == ch) ? 8'(v) : 8'($urandom_range(0, v));
    endtask

    task automatic run_iter(input int v);
        set_max(v);
        tick();
        tick();
    endtask

    int p0;
    int r;

    initial begin
        repeat (3) tick();
        chk("rst_enable", 32'(Enable), 0);
        chk("rst_done", 32'(Done), 0);
        rd_chk("rst_status", 2, 16'h0000);
        Reset = 1'b1;
        tick();

        // Budget exhaustion: 3 pulses, no convergence.
        bus_write(ra(1), 16'd0);
        set_all(5);
        p0 = pulses;
        bus_write(ra(0), 16'd3);
        repeat (8) tick();
        chk("t1_pulses", 32'(pulses - p0), 3);
        chk("t1_done", 32'(Done), 1);
        chk("t1_conv", 32'(Converged), 0);
        rd_chk("t1_status", 2, 16'h0037);
        chk("t1_model_iters", 32'(m_iters), 3);

        // Early exit: 9,3,2 with THRESH=4 converges at iteration 3.
        bus_write(ra(1), 16'd4);
        bus_write(ra(0), 16'd10);
        run_iter(9); run_iter(3); run_iter(2);
        tick();
        chk("t2_conv", 32'(Converged), 1);
        rd_chk("t2_status", 2, 16'h003F);
        rd_chk("t2_remaining", 0, 16'd7);

        // Interrupted convergence: 3,9,3,3 exits at iteration 4.
        bus_write(ra(0), 16'd10);
        run_iter(3); run_iter(9); run_iter(3); run_iter(3);
        tick();
        rd_chk("t3_status", 2, 16'h004F);
        chk("t3_model_iters", 32'(m_iters), 4);

        // ITER=0 finishes at once with no pulse.
        p0 = pulses;
        bus_write(ra(0), 16'd0);
        rd_chk("t4_status_zero", 2, 16'h0007);
        repeat (3) tick();
        chk("t4_no_pulse", 32'(pulses - p0), 0);

        // Restart mid-run: exactly 5 pulses after the new write.
        set_all(200);
        bus_write(ra(0), 16'd8);
        repeat (3) tick();
        p0 = pulses;
        bus_write(ra(0), 16'd5);
        repeat (12) tick();
        chk("t4_restart_pulses", 32'(pulses - p0), 5);
        rd_chk("t4_restart_status", 2, 16'h0057);

        // Abort in STEP after two iterations.
        bus_write(ra(0), 16'd5);
        repeat (4) tick();
        bus_write(ra(3), 16'h0001);
        chk("t5_abort_enable", 32'(Enable), 0);
        chk("t5_abort_done", 32'(Done), 0);
        rd_chk("t5_abort_status", 2, 16'h0020);
        rd_chk("t5_abort_remaining", 0, 16'd3);

        // Asynchronous reset in EVAL, then in STEP.
        bus_write(ra(0), 16'd5);
        repeat (3) tick();
        #1 Reset = 1'b0;
        chk("t6_rst_enable", 32'(Enable), 0);
        rd_chk("t6_rst_status", 2, 16'h0000);
        rd_chk("t6_rst_thresh", 1, 16'h0000);
        tick();
        Reset = 1'b1;
        tick();
        bus_write(ra(0), 16'd5);
        chk("t6_step_enable", 32'(Enable), 1);
        #1 Reset = 1'b0;
        #1 chk("t6_async_enable", 32'(Enable), 0);
        tick();
        Reset = 1'b1;
        tick();

        // Channel 3 carries the only nonzero delta.
        Delta = {8'd7, 8'd0, 8'd0, 8'd0};
        bus_write(ra(1), 16'd6);
        bus_write(ra(0), 16'd3);
        repeat (7) tick();
        rd_chk("t7_thresh6_status", 2, 16'h0037);
        bus_write(ra(1), 16'd7);
        bus_write(ra(0), 16'd3);
        repeat (5) tick();
        rd_chk("t7_thresh7_status", 2, 16'h002F);
        rd_chk("t7_unmapped_hi", 4, GlobalDataHighZ);
        rd_chk("t7_unmapped_lo", -1, GlobalDataHighZ);

        // Randomized traffic, first with a wrapping base address.
        for (int ph = 0; ph < 2; ph++) begin
            Id = (ph == 0) ? 8'hFE : 8'($urandom);
            for (int n = 0; n < 3000; n++) begin
                r = $urandom_range(0, 99);
                WR = 1'b0;
                RD = 1'($urandom_range(0, 1));
                Addr = ($urandom_range(0, 9) < 8) ? ra($urandom_range(0, 3)) : 8'($urandom);
                for (int c = 0; c < NCH; c++)
                    Delta[c*WIDTH +: WIDTH] = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                                                          : 8'($urandom_range(0, 12));
                if (r < 3) begin
                    WR = 1'b1; Addr = ra(0); DataIn = {8'($urandom), 8'($urandom_range(0, 12))};
                end else if (r < 5) begin
                    WR = 1'b1; Addr = ra(1); DataIn = {8'($urandom), 8'($urandom_range(0, 14))};
                end else if (r < 6) begin
                    WR = 1'b1; Addr = ra(3); DataIn = 16'($urandom);
                end else if (r < 8) begin
                    WR = 1'b1; Addr = 8'($urandom); DataIn = {8'($urandom), 8'($urandom_range(0, 12))};
                end
                tick();
            end
            WR = 1'b0;
            RD = 1'b0;
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
